// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================
// Package : sobel_pkg
// Shared state encoding and kernel arithmetic widths for sobel.
// Rev     : 1.0
// ============================================================
package sobel_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int PIX_W   = 8;
  localparam int SAT_MAX = 255;
  localparam int GRAD_W  = 12;
  localparam int MAG_W   = 11;

  // |g| fits in MAG_W bits because each gradient is bounded by +/-1020
  function automatic logic [MAG_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
    logic signed [GRAD_W-1:0] a;
    a = g[GRAD_W-1] ? -g : g;
    return a[MAG_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_kernel.sv
`default_nettype none
// ============================================================
// Module : sobel_kernel
// Combinational 3x3 Sobel |Gx|+|Gy| saturated to the output width.
// Rev    : 1.0
// ============================================================
module sobel_kernel
  import sobel_pkg::*;
#(
  parameter int DIN_W  = PIX_W,
  parameter int DOUT_W = 8
) (
  input  logic [2:0][2:0][DIN_W-1:0] win,
  output logic [DOUT_W-1:0]          mag_sat
);

  function automatic logic signed [GRAD_W-1:0] ext(input logic [DIN_W-1:0] p);
    return signed'({{(GRAD_W-DIN_W){1'b0}}, p});
  endfunction

  logic signed [GRAD_W-1:0] w_gx;
  logic signed [GRAD_W-1:0] w_gy;
  logic [MAG_W-1:0]         w_mag;
  logic                     w_unused_centre;

  // win[row][col], row 0 = top, col 0 = left
  assign w_gx = (ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2]))
              - (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]));
  assign w_gy = (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2]))
              - (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(win[0][2]));

  assign w_mag   = abs_grad(w_gx) + abs_grad(w_gy);
  assign mag_sat = (w_mag > MAG_W'(SAT_MAX)) ? DOUT_W'(SAT_MAX) : DOUT_W'(w_mag);

  assign w_unused_centre = ^win[1][1];

endmodule
`default_nettype wire

// File: rtl/sobel.sv
`default_nettype none
// ============================================================
// Module : sobel
// Raster-order 3x3 Sobel edge stage between two FWFT FIFOs.
// Rev    : 1.0
// ============================================================
module sobel
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH       = 720,
  parameter int IMG_HEIGHT      = 540,
  parameter int FIFO_DWIDTH_IN  = 8,
  parameter int FIFO_DWIDTH_OUT = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       fifo_in_rd_en,
  input  logic [FIFO_DWIDTH_IN-1:0]  fifo_in_dout,
  input  logic                       fifo_in_empty,
  output logic                       fifo_out_wr_en,
  output logic [FIFO_DWIDTH_OUT-1:0] fifo_out_din,
  input  logic                       fifo_out_full
);

  localparam int SR_LEN = 2*IMG_WIDTH + 3;
  localparam int CNT_W  = $clog2(IMG_WIDTH*IMG_HEIGHT);
  localparam int COL_W  = $clog2(IMG_WIDTH);
  localparam int ROW_W  = $clog2(IMG_HEIGHT);

  localparam logic [CNT_W-1:0] C_FILL_LAST = CNT_W'(IMG_WIDTH);
  localparam logic [CNT_W-1:0] C_PIX_LAST  = CNT_W'(IMG_WIDTH*IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] C_COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] C_ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);

  state_t                     r_state;
  state_t                     w_state_next;
  logic [FIFO_DWIDTH_IN-1:0]  r_sr [0:SR_LEN-1];
  logic [CNT_W-1:0]           r_in_cnt;
  logic [ROW_W-1:0]           r_row;
  logic [COL_W-1:0]           r_col;
  logic [FIFO_DWIDTH_OUT-1:0] r_out_reg;
  logic                       r_out_valid;
  logic                       w_emit;
  logic                       w_border;
  logic [FIFO_DWIDTH_OUT-1:0] w_mag;
  logic [2:0][2:0][FIFO_DWIDTH_IN-1:0] w_win;

  // The window is taken as it will look after this cycle's shift, so the
  // incoming pixel is the bottom-right tap and the rest come from sr one step back.
  for (genvar gi = 0; gi < 3; gi++) begin : g_row
    for (genvar gj = 0; gj < 3; gj++) begin : g_col
      if (gi == 2 && gj == 2) begin : g_newest
        assign w_win[gi][gj] = fifo_in_dout;
      end else begin : g_stored
        assign w_win[gi][gj] = r_sr[(2-gi)*IMG_WIDTH + (2-gj) - 1];
      end
    end
  end

  sobel_kernel #(
    .DIN_W  (FIFO_DWIDTH_IN),
    .DOUT_W (FIFO_DWIDTH_OUT)
  ) u_kernel (
    .win     (w_win),
    .mag_sat (w_mag)
  );

  always_comb begin
    w_state_next  = r_state;
    fifo_in_rd_en = 1'b0;
    w_emit        = 1'b0;
    case (r_state)
      ST_FILL: begin
        fifo_in_rd_en = !fifo_in_empty;
        if (fifo_in_rd_en && r_in_cnt == C_FILL_LAST) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        fifo_in_rd_en = !fifo_in_empty && (!r_out_valid || !fifo_out_full);
        w_emit        = fifo_in_rd_en;
        if (fifo_in_rd_en && r_in_cnt == C_PIX_LAST) w_state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        w_emit = !r_out_valid || !fifo_out_full;
        if (w_emit && r_row == C_ROW_LAST && r_col == C_COL_LAST) w_state_next = ST_FILL;
      end
      default: w_state_next = ST_FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_FILL;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < SR_LEN; k++) r_sr[k] <= '0;
    end else if (fifo_in_rd_en) begin
      r_sr[0] <= fifo_in_dout;
      for (int k = 1; k < SR_LEN; k++) r_sr[k] <= r_sr[k-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_in_cnt <= '0;
    end else if (fifo_in_rd_en) begin
      r_in_cnt <= (r_in_cnt == C_PIX_LAST) ? '0 : r_in_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_emit) begin
      if (r_col == C_COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == C_ROW_LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign w_border = (r_row == '0) || (r_row == C_ROW_LAST) ||
                    (r_col == '0) || (r_col == C_COL_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_reg   <= '0;
      r_out_valid <= 1'b0;
    end else if (w_emit) begin
      r_out_reg   <= (w_border || r_state == ST_FLUSH) ? '0 : w_mag;
      r_out_valid <= 1'b1;
    end else if (fifo_out_wr_en) begin
      r_out_valid <= 1'b0;
    end
  end

  assign fifo_out_wr_en = r_out_valid && !fifo_out_full;
  assign fifo_out_din   = r_out_reg;

endmodule
`default_nettype wire

// File: tb/tb_sobel.sv
`default_nettype none
// ============================================================
// Module : tb_sobel
// Scoreboard bench for sobel against a direct image-domain model.
// Rev    : 1.0
// ============================================================
module tb_sobel;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W*H;

  logic       clock;
  logic       reset;
  logic       fifo_in_rd_en;
  logic [7:0] fifo_in_dout;
  logic       fifo_in_empty;
  logic       fifo_out_wr_en;
  logic [7:0] fifo_out_din;
  logic       fifo_out_full;

  sobel #(
    .IMG_WIDTH       (W),
    .IMG_HEIGHT      (H),
    .FIFO_DWIDTH_IN  (8),
    .FIFO_DWIDTH_OUT (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .fifo_in_rd_en  (fifo_in_rd_en),
    .fifo_in_dout   (fifo_in_dout),
    .fifo_in_empty  (fifo_in_empty),
    .fifo_out_wr_en (fifo_out_wr_en),
    .fifo_out_din   (fifo_out_din),
    .fifo_out_full  (fifo_out_full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         wr_cnt  = 0;
  int         pop_cnt = 0;
  int         out_idx = 0;
  bit         rand_gap   = 0;
  bit         rand_full  = 0;
  bit         force_full = 0;
  bit         pop_pending;
  logic [7:0] in_q[$];
  logic [7:0] exp_q[$];
  int         img[H][W];

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Gradient straight from the image: right column minus left, bottom row minus top.
  function automatic int ref_pixel(input int r, input int c);
    int gx, gy, m;
    if (r == 0 || r == H-1 || c == 0 || c == W-1) return 0;
    gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
       - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
    gy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
       - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 255 : m;
  endfunction

  task automatic send_frame();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        in_q.push_back(8'(img[r][c]));
        exp_q.push_back(8'(ref_pixel(r, c)));
      end
  endtask

  task automatic fill_uniform(input int v);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = v;
  endtask

  task automatic fill_step(input int lo, input int hi);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (c < 4) ? lo : hi;
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(0, 255));
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || in_q.size() != 0) && k < budget) begin
      step();
      k++;
    end
    n_tests++;
    if (exp_q.size() != 0 || in_q.size() != 0) begin
      n_fail++;
      $display("FAIL frame_timeout: %0d outputs and %0d inputs still pending", exp_q.size(), in_q.size());
    end
    rand_gap  = 0;
    rand_full = 0;
    repeat (4) step();
  endtask

  task automatic wait_pops(input int target, input int budget);
    int k;
    k = 0;
    while (pop_cnt < target && k < budget) begin
      step();
      k++;
    end
    n_tests++;
    if (pop_cnt < target) begin
      n_fail++;
      $display("FAIL pop_timeout: got %0d reads, expected at least %0d", pop_cnt, target);
    end
  endtask

  task automatic run_frame(input string name, input int budget);
    wr_cnt  = 0;
    pop_cnt = 0;
    send_frame();
    wait_done(budget);
    check({name, "_wr_count"}, wr_cnt, N);
    check({name, "_rd_count"}, pop_cnt, N);
  endtask

  // Input FIFO (FWFT) and output-full model; updates land just after the rising edge.
  initial begin
    fifo_in_empty = 1'b1;
    fifo_in_dout  = 8'd0;
    fifo_out_full = 1'b0;
    forever begin
      @(negedge clock);
      pop_pending = fifo_in_rd_en && !fifo_in_empty && !reset;
      @(posedge clock);
      #1;
      if (pop_pending && in_q.size() > 0) begin
        void'(in_q.pop_front());
        pop_cnt++;
      end
      fifo_in_empty = (in_q.size() == 0) || (rand_gap && $urandom_range(0, 3) == 0);
      fifo_in_dout  = (in_q.size() != 0) ? in_q[0] : 8'd0;
      fifo_out_full = force_full || (rand_full && $urandom_range(0, 2) == 0);
    end
  end

  // Output monitor / scoreboard
  always @(negedge clock) begin
    if (!reset && fifo_out_wr_en) begin
      wr_cnt++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got %0d, expected no output", fifo_out_din);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (fifo_out_din !== e) begin
          n_fail++;
          $display("FAIL out_pixel[%0d]: got %0d, expected %0d", out_idx, fifo_out_din, e);
        end
      end
      out_idx++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] held;
    reset = 1'b1;
    repeat (3) step();
    @(negedge clock);
    check("reset_wr_en", int'(fifo_out_wr_en), 0);
    check("reset_din",   int'(fifo_out_din),   0);
    check("reset_rd_en", int'(fifo_in_rd_en),  0);
    step();
    reset = 1'b0;

    fill_uniform(100);   run_frame("uniform", 1000);
    fill_step(10, 20);   run_frame("step", 1000);
    fill_step(0, 255);   run_frame("saturate", 1000);

    for (int f = 0; f < 3; f++) begin
      fill_random();
      rand_gap  = 1;
      rand_full = 1;
      run_frame("random", 3000);
    end

    // Same random frame unstalled, then with a 5-cycle full stall mid-RUN
    fill_random();
    run_frame("prestall", 1000);
    wr_cnt  = 0;
    pop_cnt = 0;
    send_frame();
    wait_pops(20, 500);
    force_full = 1;
    step();
    @(negedge clock);
    held = fifo_out_din;
    check("stall_rd_en", int'(fifo_in_rd_en), 0);
    check("stall_wr_en", int'(fifo_out_wr_en), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("stall_rd_en", int'(fifo_in_rd_en), 0);
      check("stall_din_hold", int'(fifo_out_din), int'(held));
    end
    force_full = 0;
    wait_done(1000);
    check("stall_wr_count", wr_cnt, N);
    check("stall_rd_count", pop_cnt, N);

    // Reset mid-frame, then a clean uniform frame
    fill_random();
    pop_cnt = 0;
    send_frame();
    wait_pops(20, 500);
    reset = 1'b1;
    step();
    step();
    in_q.delete();
    exp_q.delete();
    @(negedge clock);
    check("midreset_wr_en", int'(fifo_out_wr_en), 0);
    check("midreset_din",   int'(fifo_out_din),   0);
    step();
    reset = 1'b0;
    fill_uniform(100);
    run_frame("after_reset", 1000);

    // Back-to-back frames queued together
    wr_cnt  = 0;
    pop_cnt = 0;
    fill_step(10, 20);
    send_frame();
    fill_uniform(100);
    send_frame();
    wait_done(2000);
    check("b2b_wr_count", wr_cnt, 2*N);
    check("b2b_rd_count", pop_cnt, 2*N);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sobel.md
# sobel

Edge-detection stage directly downstream of grayscale in the image pipeline. It reads 8-bit grayscale pixels in raster order from the FIFO that grayscale fills. For each pixel it computes the 3x3 Sobel gradient magnitude |Gx|+|Gy|, saturated to 8 bits. Results go to an output FIFO in the same raster order: exactly one output per input pixel, with border pixels forced to zero.

## Interface
Parameters:
- IMG_WIDTH, 720, pixels per row (>= 3)
- IMG_HEIGHT, 540, rows per frame (>= 3)
- FIFO_DWIDTH_IN, 8, input pixel width
- FIFO_DWIDTH_OUT, 8, output pixel width

Ports:
- clock  in  1  single clock domain; one clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- fifo_in_rd_en  out  1  pop input FIFO; first-word-fall-through, so dout is valid while empty=0
- fifo_in_dout  in  FIFO_DWIDTH_IN  grayscale pixel
- fifo_in_empty  in  1  input FIFO empty
- fifo_out_wr_en  out  1  push output FIFO
- fifo_out_din  out  FIFO_DWIDTH_OUT  gradient pixel
- fifo_out_full  in  1  output FIFO full

## Operation
- Window storage is a pixel shift register sr[0..2*IMG_WIDTH+2].
  - Every accepted input shifts in at sr[0].
  - Window p[i][j] (i = row top→bottom, j = col left→right) is sr[(2-i)*IMG_WIDTH + (2-j)].
  - The window centre is the pixel IMG_WIDTH+1 positions behind the newest.
- Kernel:
  - Gx = (p02 + 2p12 + p22) - (p00 + 2p10 + p20)
  - Gy = (p20 + 2p21 + p22) - (p00 + 2p01 + p02)
  - Both are 12-bit signed (range ±1020).
  - mag = |Gx| + |Gy| (11-bit unsigned, ≤ 2040).
  - out = (mag > 255) ? 255 : mag.
- Border: if the centre row is 0 or IMG_HEIGHT-1, or the centre col is 0 or IMG_WIDTH-1, then out = 0.
- Counters:
  - in_cnt counts accepted inputs (0..W*H-1).
  - The centre row/col counters advance with each emitted output and wrap col at IMG_WIDTH-1 and row at IMG_HEIGHT-1.
- FSM:
  - FILL: accept inputs and emit nothing. When the (IMG_WIDTH+1)th pixel is accepted → RUN.
  - RUN: each accepted input produces one output for the current centre. When the last pixel of the frame (in_cnt = W*H-1) is accepted → FLUSH.
  - FLUSH: read nothing. Emit IMG_WIDTH+1 outputs, which are all border pixels and therefore 0. Then → FILL with all counters cleared, ready for the next frame.
- Acceptance rule:
  - FILL: fifo_in_rd_en = !fifo_in_empty.
  - RUN: fifo_in_rd_en = !fifo_in_empty && (!out_valid || !fifo_out_full).
- Output register:
  - One entry, out_reg/out_valid. It loads when an output is produced and clears when drained.
  - fifo_out_wr_en = out_valid && !fifo_out_full. fifo_out_din = out_reg.
  - Load and drain in the same cycle is allowed and keeps out_valid = 1.
- Backpressure: when fifo_out_full = 1 and out_valid = 1, the block must not read input or shift sr, and out_reg holds.
- Reset: state = FILL; all counters, out_valid, and sr cleared.
  - Reset mid-frame discards the partial frame.
  - The next pixel read is treated as pixel (0,0).

## Timing
- Outputs after reset: fifo_in_rd_en = 0 while empty, fifo_out_wr_en = 0, fifo_out_din = 0.
- The output for centre (r,c) is registered in the cycle after input (r+1,c+1) is accepted.
  - fifo_out_wr_en rises that cycle if the output FIFO is not full.
- Throughput: 1 pixel/clock in RUN when unstalled.
  - FLUSH emits 1 pixel/clock subject to full.
- Frame cost: W*H reads and W*H writes, with no dropped or duplicated pixels.
- A FILL of the next frame overlaps only after FLUSH completes.

## Structure
- Shared package holds:
  - the state encoding (FILL, RUN, FLUSH);
  - the saturation constant 255;
  - the kernel arithmetic widths (12-bit signed gradient, 11-bit magnitude).
- One sub-module, sobel_kernel: purely combinational, 9×8-bit window in → 8-bit saturated magnitude out.
  - The top level owns the FSM, counters, shift register, border mask and output register.

## Test plan
Bench parameters: IMG_WIDTH = 8, IMG_HEIGHT = 6.
- Uniform frame, all pixels 100 → 48 outputs, all 0, in order; wr_en count = 48.
- Vertical step, cols 0–3 = 10 and cols 4–7 = 20 → interior cols 3 and 4 = 40, other interior cols = 0, border = 0.
- Saturation, cols 0–3 = 0 and cols 4–7 = 255 → interior cols 3 and 4 = 255, not 1020 truncated.
- Backpressure: hold fifo_out_full = 1 for 5 cycles mid-RUN → no rd_en during the stall, fifo_out_din stable, and the output stream is identical to the unstalled run.
- Reset asserted after 20 pixels, then a full uniform-100 frame → exactly 48 outputs, all 0, and no stale data.
- Two back-to-back frames, step then uniform → 96 outputs; frame 2 is unaffected by frame 1, and FLUSH zeros appear before frame 2 data.
